// File: rtl/dpll_flb_pkg.sv
// ---------------------------------------------------------------------------
// dpll_flb_pkg
//   Constants and types shared by the DCO code sequencer and its
//   slew / column-boundary limiter.
//   CODE_W      : width of the capacitor-matrix code (s_mtrx)
//   COL_SIZE    : codes per matrix column (power of 2)
//   seq_state_t : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package dpll_flb_pkg;

  localparam int CODE_W   = 8;
  localparam int COL_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dco_step_limit.sv
// ---------------------------------------------------------------------------
// dco_step_limit
//   Combinational next-code calculation for the DCO code ramp. Moves the
//   current code toward the target by at most MAX_STEP, never past the
//   target, and never across a column boundary (landing on one is allowed).
//   The result is clamped to [CODE_MIN, CODE_MAX].
// Ports
//   i_cur  in  CODE_W  current s_mtrx code
//   i_tgt  in  CODE_W  latched (already clamped) target code
//   o_next out CODE_W  code to apply on the next update
// ---------------------------------------------------------------------------
import dpll_flb_pkg::*;

module dco_step_limit #(
  parameter int CODE_W   = dpll_flb_pkg::CODE_W,
  parameter int MAX_STEP = 4,
  parameter int COL_SIZE = dpll_flb_pkg::COL_SIZE,
  parameter int CODE_MIN = 0,
  parameter int CODE_MAX = 255
) (
  input  logic [CODE_W-1:0] i_cur,
  input  logic [CODE_W-1:0] i_tgt,
  output logic [CODE_W-1:0] o_next
);

  // Two extra bits so cur+MAX_STEP and cur-MAX_STEP never wrap.
  localparam int W = CODE_W + 2;
  typedef logic signed [W-1:0] sw_t;

  localparam sw_t STEP_S = sw_t'(MAX_STEP);
  localparam sw_t COL_S  = sw_t'(COL_SIZE);
  localparam sw_t MASK_S = sw_t'(COL_SIZE - 1);
  localparam sw_t MIN_S  = sw_t'(CODE_MIN);
  localparam sw_t MAX_S  = sw_t'(CODE_MAX);
  localparam sw_t ONE_S  = sw_t'(1);

  sw_t w_cur;
  sw_t w_tgt;
  sw_t w_lim;
  sw_t w_bnd;
  sw_t w_res;

  always_comb begin
    w_cur = $signed({2'b00, i_cur});
    w_tgt = $signed({2'b00, i_tgt});
    w_lim = '0;
    w_bnd = '0;
    w_res = w_cur;
    if (w_tgt > w_cur) begin
      w_lim = w_cur + STEP_S;
      // first code of the next column up
      w_bnd = (w_cur | MASK_S) + ONE_S;
      w_res = w_lim;
      if (w_tgt < w_res) w_res = w_tgt;
      if (w_bnd < w_res) w_res = w_bnd;
    end else if (w_tgt < w_cur) begin
      w_lim = w_cur - STEP_S;
      // sitting on a boundary: the floor is the start of the column below
      if ((w_cur & MASK_S) == '0) w_bnd = w_cur - COL_S;
      else                        w_bnd = w_cur & ~MASK_S;
      w_res = w_lim;
      if (w_tgt > w_res) w_res = w_tgt;
      if (w_bnd > w_res) w_res = w_bnd;
    end
    if (w_res < MIN_S) w_res = MIN_S;
    if (w_res > MAX_S) w_res = MAX_S;
    o_next = CODE_W'(w_res);
  end

endmodule

// File: rtl/dco_code_sequencer.sv
// ---------------------------------------------------------------------------
// dco_code_sequencer
//   Slew-limited sequencer feeding the DCO capacitor-matrix decoder. Accepts
//   a target code over valid/ready, then ramps s_mtrx toward it one bounded
//   step at a time with SETTLE_CYC idle cycles after each step.
// Ports
//   clk        in   1       clock, posedge
//   rst        in   1       synchronous active-high reset
//   tgt_code   in   CODE_W  requested target code
//   tgt_valid  in   1       tgt_code valid
//   tgt_ready  out  1       high in IDLE; targets offered otherwise are dropped
//   freeze     in   1       hold s_mtrx, suppress new steps
//   s_mtrx     out  CODE_W  registered code to the decoder
//   s_mtrx_upd out  1       one-cycle pulse coincident with each new s_mtrx
//   busy       out  1       ramp in progress
//   at_target  out  1       s_mtrx equals last accepted (clamped) target
//
// state  | meaning
// IDLE   | waiting for a target; s_mtrx stable
// STEP   | apply next code (held while freeze=1)
// SETTLE | count down SETTLE_CYC cycles after a step
// ---------------------------------------------------------------------------
import dpll_flb_pkg::*;

module dco_code_sequencer #(
  parameter int CODE_W     = dpll_flb_pkg::CODE_W,
  parameter int MAX_STEP   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int COL_SIZE   = dpll_flb_pkg::COL_SIZE,
  parameter int CODE_MIN   = 0,
  parameter int CODE_MAX   = 255,
  parameter int RST_CODE   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic              freeze,
  output logic [CODE_W-1:0] s_mtrx,
  output logic              s_mtrx_upd,
  output logic              busy,
  output logic              at_target
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_t        r_state, w_state_nxt;
  logic [CODE_W-1:0] r_mtrx,  w_mtrx_nxt;
  logic [CODE_W-1:0] r_tgt,   w_tgt_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic              r_upd,   w_upd_nxt;
  logic              r_at,    w_at_nxt;
  logic [CODE_W-1:0] w_tgt_clamp;
  logic [CODE_W-1:0] w_step;

  dco_step_limit #(
    .CODE_W   (CODE_W),
    .MAX_STEP (MAX_STEP),
    .COL_SIZE (COL_SIZE),
    .CODE_MIN (CODE_MIN),
    .CODE_MAX (CODE_MAX)
  ) u_step_limit (
    .i_cur  (r_mtrx),
    .i_tgt  (r_tgt),
    .o_next (w_step)
  );

  always_comb begin
    w_tgt_clamp = tgt_code;
    if (tgt_code < CODE_W'(CODE_MIN)) w_tgt_clamp = CODE_W'(CODE_MIN);
    if (tgt_code > CODE_W'(CODE_MAX)) w_tgt_clamp = CODE_W'(CODE_MAX);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mtrx_nxt  = r_mtrx;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    w_upd_nxt   = 1'b0;
    w_at_nxt    = r_at;
    case (r_state)
      IDLE: begin
        if (tgt_valid) begin
          w_tgt_nxt = w_tgt_clamp;
          if (w_tgt_clamp != r_mtrx) begin
            w_state_nxt = STEP;
            w_at_nxt    = 1'b0;
          end
        end
      end
      STEP: begin
        if (!freeze) begin
          w_mtrx_nxt  = w_step;
          w_upd_nxt   = 1'b1;
          w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          if (r_mtrx == r_tgt) begin
            w_state_nxt = IDLE;
            w_at_nxt    = 1'b1;
          end else begin
            w_state_nxt = STEP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mtrx  <= CODE_W'(RST_CODE);
      r_tgt   <= CODE_W'(RST_CODE);
      r_cnt   <= '0;
      r_upd   <= 1'b0;
      r_at    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_mtrx  <= w_mtrx_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_upd   <= w_upd_nxt;
      r_at    <= w_at_nxt;
    end
  end

  assign s_mtrx     = r_mtrx;
  assign s_mtrx_upd = r_upd;
  assign tgt_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign at_target  = r_at;

endmodule

// File: tb/tb_dco_code_sequencer.sv
module tb_dco_code_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst, tgt_valid, freeze;
  logic [7:0] tgt_code;
  logic       tgt_ready, s_mtrx_upd, busy, at_target;
  logic [7:0] s_mtrx;

  // CODE_MIN=8 instance
  logic       m_rst, m_tgt_valid, m_freeze;
  logic [7:0] m_tgt_code;
  logic       m_tgt_ready, m_s_mtrx_upd, m_busy, m_at_target;
  logic [7:0] m_s_mtrx;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  dco_code_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_code   (tgt_code),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .freeze     (freeze),
    .s_mtrx     (s_mtrx),
    .s_mtrx_upd (s_mtrx_upd),
    .busy       (busy),
    .at_target  (at_target)
  );

  dco_code_sequencer #(.CODE_MIN(8)) dut_min (
    .clk        (clk),
    .rst        (m_rst),
    .tgt_code   (m_tgt_code),
    .tgt_valid  (m_tgt_valid),
    .tgt_ready  (m_tgt_ready),
    .freeze     (m_freeze),
    .s_mtrx     (m_s_mtrx),
    .s_mtrx_upd (m_s_mtrx_upd),
    .busy       (m_busy),
    .at_target  (m_at_target)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int col_of(input int v);
    return v / 16;
  endfunction

  task automatic send(input int t);
    @(negedge clk);
    tgt_code  = 8'(t);
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  // Follows a ramp to completion, checking every pulse against exp_q.
  // first_gap > 0 checks the latency from the accept edge to the first pulse.
  task automatic collect(input string tag, input int first_gap);
    int  idx, last, cyc, prev, d;
    bit  done;
    idx = 0; last = 0; cyc = 0; done = 0;
    prev = int'(s_mtrx);
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (s_mtrx_upd) begin
        if (idx < exp_q.size()) check({tag, "_code"}, int'(s_mtrx), exp_q[idx]);
        else                    check({tag, "_extra_pulse"}, int'(s_mtrx), -1);
        if (idx > 0)            check({tag, "_gap"}, cyc - last, 3);
        else if (first_gap > 0) check({tag, "_latency"}, cyc, first_gap);
        d = col_of(int'(s_mtrx)) - col_of(prev);
        check({tag, "_col_step"}, int'(d <= 1 && d >= -1), 1);
        last = cyc;
        idx++;
      end else begin
        check({tag, "_stable"}, int'(s_mtrx), prev);
      end
      prev = int'(s_mtrx);
      if (!busy) done = 1;
      else if (cyc > 400) begin
        check({tag, "_timeout"}, 0, 1);
        done = 1;
      end
    end
    check({tag, "_npulses"}, idx, exp_q.size());
    check({tag, "_final"}, int'(s_mtrx), exp_q[exp_q.size()-1]);
    check({tag, "_at_target"}, int'(at_target), 1);
    check({tag, "_ready"}, int'(tgt_ready), 1);
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, "_s_mtrx"}, int'(s_mtrx), 128);
    check({tag, "_ready"}, int'(tgt_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_at_target"}, int'(at_target), 1);
    check({tag, "_upd"}, int'(s_mtrx_upd), 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst = 1'b1; tgt_valid = 1'b0; freeze = 1'b0; tgt_code = '0;
    m_rst = 1'b1; m_tgt_valid = 1'b0; m_freeze = 1'b0; m_tgt_code = '0;

    // 1. reset
    repeat (2) @(negedge clk);
    check_reset_main("rst_held");
    rst = 1'b0; m_rst = 1'b0;
    @(negedge clk);
    check_reset_main("rst_rel");

    // 2. 128 -> 136
    send(136);
    exp_q = '{132, 136};
    collect("t2", 1);

    // 3. from 128 down to 30, through every multiple of 16
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t3_reset_code", int'(s_mtrx), 128);
    send(30);
    exp_q = {};
    for (int v = 124; v >= 32; v -= 4) exp_q.push_back(v);
    exp_q.push_back(30);
    collect("t3", 1);

    // 4. boundary behaviour around column 0/1
    send(14);
    exp_q = '{26, 22, 18, 16, 14};
    collect("t4a", 1);
    send(25);
    exp_q = '{16, 20, 24, 25};
    collect("t4b", 1);
    send(16);
    exp_q = '{21, 17, 16};
    collect("t4c", 1);
    send(5);
    exp_q = '{12, 8, 5};
    collect("t4d", 1);

    // 5. ignored target and freeze during ramp 5 -> 60
    send(60);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_mtrx_upd) seen = 1;
    end
    check("t5_first_seen", int'(seen), 1);
    check("t5_first_code", int'(s_mtrx), 9);
    tgt_code  = 8'd200;
    tgt_valid = 1'b1;
    freeze    = 1'b1;
    check("t5_ready_low", int'(tgt_ready), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tgt_valid = 1'b0;
      check("t5_frz_upd", int'(s_mtrx_upd), 0);
      check("t5_frz_code", int'(s_mtrx), 9);
      check("t5_frz_busy", int'(busy), 1);
    end
    freeze = 1'b0;
    exp_q = '{13, 16};
    for (int v = 20; v <= 60; v += 4) exp_q.push_back(v);
    collect("t5", 0);

    // 6. CODE_MIN=8 instance: clamp, equal target, reset mid-ramp
    @(negedge clk);
    m_tgt_code  = 8'd2;
    m_tgt_valid = 1'b1;
    @(negedge clk);
    m_tgt_valid = 1'b0;
    check("t6_busy", int'(m_busy), 1);
    cyc = 0;
    while (m_busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_no_timeout", int'(cyc < 500), 1);
    check("t6_clamp_code", int'(m_s_mtrx), 8);
    check("t6_at_target", int'(m_at_target), 1);

    @(negedge clk);
    m_tgt_code  = 8'd3;
    m_tgt_valid = 1'b1;
    @(negedge clk);
    m_tgt_valid = 1'b0;
    check("t6_eq_busy", int'(m_busy), 0);
    check("t6_eq_upd", int'(m_s_mtrx_upd), 0);
    check("t6_eq_at", int'(m_at_target), 1);
    check("t6_eq_code", int'(m_s_mtrx), 8);

    m_tgt_code  = 8'd200;
    m_tgt_valid = 1'b1;
    @(negedge clk);
    m_tgt_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t6_ramping", int'(m_busy), 1);
    check("t6_ramp_moved", int'(m_s_mtrx > 8'd8), 1);
    m_rst = 1'b1;
    @(negedge clk);
    m_rst = 1'b0;
    check("t6_rst_code", int'(m_s_mtrx), 128);
    check("t6_rst_busy", int'(m_busy), 0);
    check("t6_rst_ready", int'(m_tgt_ready), 1);
    check("t6_rst_at", int'(m_at_target), 1);
    check("t6_rst_upd", int'(m_s_mtrx_upd), 0);
    repeat (4) @(negedge clk);
    check("t6_abandoned", int'(m_s_mtrx), 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
